// File: rtl/mem_responder_pkg.sv
// Shared processor definitions: memory-responder FSM encodings and bus widths
// used by both the control unit and the memory responder.
package mem_responder_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder_mem_array.sv
// DEPTH x DATA_W word store: synchronous write, registered read port that holds
// its value between reads. Reset clears every word and the read register.
module mem_responder_mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] rdata_reg;
  logic [DEPTH-1:0]  word_sel;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_sel
      assign word_sel[gi] = we && (addr == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (word_sel[i]) begin
          mem_reg[i] <= wdata;
        end
      end
    end
  end

  // Addresses beyond DEPTH read back as zero rather than aliasing.
  always_ff @(posedge clk) begin
    if (srst) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= (int'(addr) < DEPTH) ? mem_reg[addr] : '0;
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mem_responder.sv
// Four-phase memory responder: accepts a read or write request, waits
// WAIT_STATES+1 cycles, performs the access, then holds ack until release.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH       = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              rd,
  input  logic              we,
  output logic [DATA_W-1:0] dataOut,
  output logic              ack,
  output logic              busy,
  output logic              err,
  output logic [3:0]        ledDataOut
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              ack_reg;
  logic              busy_reg;
  logic              err_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              write_reg;

  logic access_next;
  logic mem_we_next;
  logic mem_re_next;

  // The access fires on the last WAIT cycle, coinciding with the move to ACK.
  assign access_next = (state_reg == WAIT) && (cnt_reg == WAIT_LAST);
  assign mem_we_next = access_next && write_reg;
  assign mem_re_next = access_next && !write_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ack_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
      addr_reg  <= '0;
      data_reg  <= '0;
      write_reg <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rd || we) begin
            addr_reg  <= address;
            data_reg  <= dataIn;
            write_reg <= we;
            err_reg   <= rd && we;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg == WAIT_LAST) begin
            ack_reg   <= 1'b1;
            state_reg <= ACK;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        ACK: begin
          // A request still held here is the old one; wait for the low phase.
          if (!rd && !we) begin
            ack_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          ack_reg   <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  mem_responder_mem_array #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clock),
    .srst (reset),
    .we   (mem_we_next),
    .re   (mem_re_next),
    .addr (addr_reg),
    .wdata(data_reg),
    .rdata(dataOut)
  );

  assign ack        = ack_reg;
  assign busy       = busy_reg;
  assign err        = err_reg;
  assign ledDataOut = dataOut[3:0];

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two responders (WAIT_STATES=2 and 0) share one request
// bus and are compared against a transaction-level memory model.
module tb_mem_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic       rd;
  logic       we;
  logic [3:0] address;
  logic [7:0] dataIn;

  logic [7:0] dout2, dout0;
  logic       ack2, ack0, busy2, busy0, err2, err0;
  logic [3:0] led2, led0;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] model_mem [16];
  logic [7:0] model_rd;

  always #5 clock = ~clock;

  mem_responder #(.WAIT_STATES(2), .DEPTH(16)) dut (
    .clock(clock), .reset(reset), .address(address), .dataIn(dataIn),
    .rd(rd), .we(we), .dataOut(dout2), .ack(ack2), .busy(busy2),
    .err(err2), .ledDataOut(led2)
  );

  mem_responder #(.WAIT_STATES(0), .DEPTH(16)) dut0 (
    .clock(clock), .reset(reset), .address(address), .dataIn(dataIn),
    .rd(rd), .we(we), .dataOut(dout0), .ack(ack0), .busy(busy0),
    .err(err0), .ledDataOut(led0)
  );

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    model_rd = 8'h00;
  endtask

  // One four-phase transaction on both DUTs; hold = extra cycles the request
  // stays high after both acks, scramble = disturb address/data after accept.
  task automatic run_txn(input string tag, input logic r, input logic w,
                         input logic [3:0] a, input logic [7:0] d,
                         input int hold, input bit scramble);
    int lat2, lat0, bcnt2, bcnt0;
    logic exp_err;
    logic [3:0] exp_led;
    exp_err = r & w;
    lat2 = 0; lat0 = 0; bcnt2 = 0; bcnt0 = 0;
    @(posedge clock); #1;
    rd = r; we = w; address = a; dataIn = d;
    for (int k = 1; k <= 20 && (lat2 == 0 || lat0 == 0); k++) begin
      @(posedge clock); #1;
      if (k == 1) begin
        tests_run++;
        if (err2 !== exp_err || err0 !== exp_err) begin
          tests_failed++;
          $display("FAIL %s err_accept: got %b/%b expected %b", tag, err2, err0, exp_err);
        end
        if (scramble) begin
          address = 4'($urandom);
          dataIn  = 8'($urandom);
        end
      end
      if (k == 2) begin
        tests_run++;
        if (err2 !== 1'b0 || err0 !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s err_pulse_width: got %b/%b expected 0", tag, err2, err0);
        end
      end
      if (lat2 == 0 && busy2 === 1'b1 && ack2 !== 1'b1) bcnt2++;
      if (lat0 == 0 && busy0 === 1'b1 && ack0 !== 1'b1) bcnt0++;
      if (lat2 == 0 && ack2 === 1'b1) lat2 = k;
      if (lat0 == 0 && ack0 === 1'b1) lat0 = k;
    end
    if (w) model_mem[a] = d;
    else   model_rd = model_mem[a];
    exp_led = model_rd[3:0];

    tests_run++;
    if (lat2 != 4 || lat0 != 2) begin
      tests_failed++;
      $display("FAIL %s ack_latency: got %0d/%0d expected 4/2", tag, lat2, lat0);
    end
    tests_run++;
    if (bcnt2 != 3 || bcnt0 != 1) begin
      tests_failed++;
      $display("FAIL %s busy_cycles: got %0d/%0d expected 3/1", tag, bcnt2, bcnt0);
    end
    tests_run++;
    if (dout2 !== model_rd || dout0 !== model_rd || led2 !== exp_led || led0 !== exp_led) begin
      tests_failed++;
      $display("FAIL %s data_at_ack: got %h/%h led %h/%h expected %h led %h",
               tag, dout2, dout0, led2, led0, model_rd, exp_led);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clock); #1;
      tests_run++;
      if (ack2 !== 1'b1 || ack0 !== 1'b1 || busy2 !== 1'b1 || busy0 !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s ack_held: got ack %b/%b busy %b/%b expected all 1",
                 tag, ack2, ack0, busy2, busy0);
      end
    end
    rd = 1'b0; we = 1'b0;
    @(posedge clock); #1;
    tests_run++;
    if (ack2 !== 1'b0 || ack0 !== 1'b0 || busy2 !== 1'b0 || busy0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s release: got ack %b/%b busy %b/%b expected all 0",
               tag, ack2, ack0, busy2, busy0);
    end
    tests_run++;
    if (dout2 !== model_rd || dout0 !== model_rd) begin
      tests_failed++;
      $display("FAIL %s data_hold: got %h/%h expected %h", tag, dout2, dout0, model_rd);
    end
    $display("[TB] txn %s rd=%b we=%b addr=%h data=%h lat=%0d/%0d dout=%h",
             tag, r, w, a, d, lat2, lat0, dout2);
  endtask

  task automatic test_reset();
    reset = 1'b1; rd = 1'b0; we = 1'b0; address = '0; dataIn = '0;
    repeat (3) @(posedge clock);
    #1;
    model_reset();
    tests_run++;
    if ({ack2, busy2, err2, dout2, led2} !== 15'd0 || {ack0, busy0, err0, dout0, led0} !== 15'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b %b %b %h %h / %b %b %b %h %h expected zeros",
               ack2, busy2, err2, dout2, led2, ack0, busy0, err0, dout0, led0);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    run_txn("write_a5", 1'b0, 1'b1, 4'd3, 8'hA5, 0, 1'b0);
    run_txn("read_a5", 1'b1, 1'b0, 4'd3, 8'h00, 0, 1'b0);
  endtask

  task automatic test_collision();
    run_txn("rdwe_3c", 1'b1, 1'b1, 4'd7, 8'h3C, 0, 1'b1);
    run_txn("read_3c", 1'b1, 1'b0, 4'd7, 8'h00, 0, 1'b0);
  endtask

  task automatic test_hold_request();
    run_txn("hold_rd", 1'b1, 1'b0, 4'd3, 8'h00, 3, 1'b0);
    run_txn("after_hold", 1'b1, 1'b0, 4'd7, 8'h00, 0, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    @(posedge clock); #1;
    we = 1'b1; address = 4'd0; dataIn = 8'hFF;
    @(posedge clock); #1;
    tests_run++;
    if (busy2 !== 1'b1 || busy0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_accepted: got busy %b/%b expected 1/1", busy2, busy0);
    end
    reset = 1'b1; we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      tests_run++;
      if (ack2 !== 1'b0 || ack0 !== 1'b0 || busy2 !== 1'b0 || busy0 !== 1'b0) begin
        tests_failed++;
        $display("FAIL abort_no_ack: got ack %b/%b busy %b/%b expected 0", ack2, ack0, busy2, busy0);
      end
    end
    reset = 1'b0;
    model_reset();
    $display("[TB] txn abort write addr=0 data=ff by reset");
    run_txn("read_aborted", 1'b1, 1'b0, 4'd0, 8'h00, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn("b2b_write", 1'b0, 1'b1, 4'd15, 8'h5A, 0, 1'b1);
    run_txn("b2b_read", 1'b1, 1'b0, 4'd15, 8'h00, 0, 1'b1);
  endtask

  task automatic test_random();
    int op;
    logic r, w;
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 2));
      r = (op != 1);
      w = (op != 0);
      run_txn("random", r, w, 4'($urandom), 8'($urandom),
              int'($urandom_range(0, 2)), 1'($urandom));
    end
  endtask

  task automatic test_reset_clears_mem();
    logic [3:0] a;
    a = 4'($urandom);
    run_txn("pre_clear", 1'b0, 1'b1, a, 8'hC3, 0, 1'b0);
    test_reset();
    run_txn("post_clear", 1'b1, 1'b0, a, 8'h00, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_collision();
    test_hold_request();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    test_reset_clears_mem();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter WAIT_STATES, default 2 (range 0..15): idle cycles between request acceptance and the memory access.
REQ-002 Parameter DEPTH, default 16: number of 8-bit words; the address width is fixed at 4 bits.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 address  input  4  word address from the control unit (endMem).
REQ-006 dataIn  input  8  write data from the control unit.
REQ-007 rd  input  1  read request, level, held until ack is seen.
REQ-008 we  input  1  write request, level, held until ack is seen.
REQ-009 dataOut  output  8  read data, valid while ack=1 after a read.
REQ-010 ack  output  1  access complete; held until the request is withdrawn.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 err  output  1  one-cycle pulse when rd and we are accepted together.
REQ-013 ledDataOut  output  4  dataOut[3:0], for board LEDs.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT, ACK.
REQ-015 IDLE: if rd|we=1, the block SHALL latch address, dataIn and the operation type, and go to WAIT; otherwise it stays in IDLE.
REQ-016 If rd=we=1 when a request is accepted, the access SHALL be a write, and err SHALL pulse high for the acceptance cycle.
REQ-017 WAIT: a counter SHALL count from 0 to WAIT_STATES; the access SHALL occur when the counter equals WAIT_STATES, and the FSM then goes to ACK.
REQ-018 With WAIT_STATES=0, WAIT SHALL last exactly one cycle, giving ack 2 cycles after the request is first seen.
REQ-019 Write access: mem[latched address] <= latched data; dataOut is unchanged.
REQ-020 Read access: dataOut <= mem[latched address]; dataOut SHALL hold its value until the next read access or reset.
REQ-021 ACK: ack=1; the FSM SHALL return to IDLE on the first cycle with rd=we=0 (four-phase handshake).
REQ-022 A request held high in ACK SHALL NOT be re-accepted; a new access requires a low phase first.
REQ-023 Changes on address/dataIn after acceptance SHALL have no effect on the current access.
REQ-024 Total latency from request sampled to ack high SHALL be WAIT_STATES+2 cycles.
REQ-025 Reads of a location written in a previous transaction SHALL return the new value (no staleness).

Reset
REQ-026 While reset=1, the block SHALL set state to IDLE, counter=0, ack=0, busy=0, err=0, dataOut=8'h00, and clear every mem word to 8'h00.
REQ-027 Reset asserted mid-WAIT or mid-ACK SHALL abort the transaction with no memory write; a request still high after reset SHALL be accepted as new.
REQ-028 Reset SHALL take priority over every other input in the same cycle.

Structure
REQ-029 State encodings (IDLE=2'd0, WAIT=2'd1, ACK=2'd2) and the 4-bit address / 8-bit data width constants SHALL live in the shared processor package used by the control unit.
REQ-030 One sub-module, mem_array (DEPTH x 8, synchronous write, registered read), is natural; the FSM stays in mem_responder.

Verification
REQ-031 Reset, then write 8'hA5 to address 3 (WAIT_STATES=2) -> ack rises 4 cycles after we; busy is high for 3 cycles.
REQ-032 Read address 3 after REQ-031 -> dataOut=8'hA5 and ledDataOut=4'h5 while ack=1; dataOut holds after rd drops.
REQ-033 rd=we=1, dataIn=8'h3C, address 7 -> err pulses for 1 cycle; a later read of address 7 returns 8'h3C.
REQ-034 Hold rd high for 3 cycles past ack -> no second access occurs; ack drops the cycle after rd=0.
REQ-035 Assert reset during WAIT of a write of 8'hFF to address 0 -> ack never rises; a read of address 0 returns 8'h00.
REQ-036 Set WAIT_STATES=0 and issue back-to-back write/read of address 15 -> each ack arrives 2 cycles after its request.
